// File: rtl/datamem_responder.sv
// ----------------------------------------------------------------------------
// datamem_responder
//
// Responder side of the CPU data-memory request interface. Accepts a single
// load/store request, waits LATENCY extra cycles to model memory latency,
// performs the access on an internal store of DEPTH words of WORDSIZE bits,
// and returns the response.
//
// Handshake semantics (both channels): a transfer happens at a posedge where
// valid and ready are both high. The producer holds valid and its payload
// stable until that transfer. Ready never depends combinationally on valid.
//
// Ports:
//   clk         clock; all state updates on posedge
//   rst         synchronous, active-high reset (also clears the store)
//   req_valid   request present
//   req_ready   responder can accept a request (high only in IDLE)
//   req_write   1 = store, 0 = load
//   req_addr    byte address; must be 8-byte aligned and below DEPTH*8
//   req_wdata   store data
//   resp_valid  response present (high only in RESP)
//   resp_ready  requester accepts the response
//   resp_rdata  load data; 0 for stores and errors
//   resp_error  request was misaligned or out of range
//
// Timing: resp_valid rises exactly LATENCY+1 posedges after the edge that
// accepted the request. After the response handshake the block spends one
// cycle in IDLE before it can accept again.
// ----------------------------------------------------------------------------
module datamem_responder #(
  parameter int WORDSIZE = 64,
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [WORDSIZE-1:0] req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                resp_error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Word index limit at the width of the full word address, so any nonzero
  // upper address bit lands out of range instead of wrapping the index.
  localparam logic [WORDSIZE-4:0] DEPTH_W = (WORDSIZE-3)'(DEPTH);

  logic [1:0]          state;
  logic [3:0]          cnt;
  logic                wr_q;
  logic [WORDSIZE-1:0] addr_q;
  logic [WORDSIZE-1:0] wdata_q;
  logic [WORDSIZE-1:0] mem [DEPTH];

  logic [IDX_W-1:0]    idx;
  logic                acc_error;

  // Only the latched request is ever examined; live req_* inputs are
  // ignored outside IDLE.
  assign idx       = addr_q[IDX_W+2:3];
  assign acc_error = (addr_q[2:0] != 3'd0) || (addr_q[WORDSIZE-1:3] >= DEPTH_W);

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 4'(LATENCY);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The counter counts down the extra latency cycles; the access
          // itself (store commit + response register) happens on the edge
          // that raises resp_valid, so a reset before then drops the store.
          if (cnt == 4'd0) begin
            if (acc_error) begin
              resp_rdata <= '0;
              resp_error <= 1'b1;
            end else if (wr_q) begin
              mem[idx]   <= wdata_q;
              resp_rdata <= '0;
              resp_error <= 1'b0;
            end else begin
              resp_rdata <= mem[idx];
              resp_error <= 1'b0;
            end
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_rdata <= '0;
            resp_error <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_responder.sv
// ----------------------------------------------------------------------------
// tb_datamem_responder
//
// Drives two responder instances: index 0 with LATENCY=2, index 1 with
// LATENCY=0. Expected responses come from a word-array model of the store
// and the address rules; an expected queue holds {error, rdata} per request.
// ----------------------------------------------------------------------------
module tb_datamem_responder;

  localparam int W     = 64;
  localparam int DEPTH = 256;
  localparam int LAT [2] = '{2, 0};

  logic         clk;
  logic         rst        [2];
  logic         req_valid  [2];
  logic         req_ready  [2];
  logic         req_write  [2];
  logic [W-1:0] req_addr   [2];
  logic [W-1:0] req_wdata  [2];
  logic         resp_valid [2];
  logic         resp_ready [2];
  logic [W-1:0] resp_rdata [2];
  logic         resp_error [2];

  logic [W-1:0] model_mem [2][DEPTH];
  logic [W:0]   exp_q [$];

  int checks = 0;
  int errors = 0;

  datamem_responder #(.WORDSIZE(W), .DEPTH(DEPTH), .LATENCY(2)) dut_lat2 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
  );

  datamem_responder #(.WORDSIZE(W), .DEPTH(DEPTH), .LATENCY(0)) dut_lat0 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_model(input int k);
    for (int i = 0; i < DEPTH; i++) model_mem[k][i] = '0;
  endtask

  // Reference rule: misaligned or word index >= DEPTH is an error.
  function automatic logic [W:0] expect_resp(input int k, input logic wr,
                                             input logic [W-1:0] addr,
                                             input logic [W-1:0] wdata);
    logic [W-1:0] word;
    word = addr >> 3;
    if (addr[2:0] != 3'd0 || word >= W'(DEPTH)) return {1'b1, {W{1'b0}}};
    if (wr) begin
      model_mem[k][int'(word)] = wdata;
      return {1'b0, {W{1'b0}}};
    end
    return {1'b0, model_mem[k][int'(word)]};
  endfunction

  // One complete request/response on instance k; stall = cycles the
  // requester holds resp_ready low after resp_valid appears.
  task automatic txn(input int k, input logic wr, input logic [W-1:0] addr,
                     input logic [W-1:0] wdata, input int stall);
    logic [W:0] exp;
    int cyc;
    exp_q.push_back(expect_resp(k, wr, addr, wdata));
    checks++;
    if (req_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready inst=%0d got=%b want=1", k, req_ready[k]);
    end
    req_valid[k]  = 1'b1;
    req_write[k]  = wr;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    resp_ready[k] = (stall == 0);
    @(negedge clk);
    // scramble request inputs; the latched copy must be used
    req_valid[k] = 1'b0;
    req_write[k] = 1'($urandom);
    req_addr[k]  = {$urandom, $urandom};
    req_wdata[k] = {$urandom, $urandom};
    cyc = 0;
    while (resp_valid[k] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != LAT[k] + 1) begin
      errors++;
      $display("FAIL latency inst=%0d got=%0d edges want=%0d", k, cyc, LAT[k] + 1);
    end
    exp = exp_q[0];
    for (int s = 0; s < stall; s++) begin
      checks++;
      if (resp_valid[k] !== 1'b1 || {resp_error[k], resp_rdata[k]} !== exp || req_ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold inst=%0d cyc=%0d got v=%b r=%b e=%b d=%h want v=1 r=0 e=%b d=%h",
                 k, s, resp_valid[k], req_ready[k], resp_error[k], resp_rdata[k], exp[W], exp[W-1:0]);
      end
      req_valid[k] = 1'($urandom);
      req_write[k] = 1'b1;
      req_addr[k]  = W'($urandom_range(0, 31)) << 3;
      req_wdata[k] = {$urandom, $urandom};
      @(negedge clk);
    end
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b1;
    exp = exp_q.pop_front();
    checks++;
    if ({resp_error[k], resp_rdata[k]} !== exp || resp_valid[k] !== 1'b1) begin
      errors++;
      $display("FAIL response inst=%0d addr=%h got v=%b e=%b d=%h want v=1 e=%b d=%h",
               k, addr, resp_valid[k], resp_error[k], resp_rdata[k], exp[W], exp[W-1:0]);
    end
    @(negedge clk);
    resp_ready[k] = 1'b0;
    checks++;
    if (resp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1 || resp_rdata[k] !== '0 || resp_error[k] !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake inst=%0d got v=%b r=%b e=%b d=%h want v=0 r=1 e=0 d=0",
               k, resp_valid[k], req_ready[k], resp_error[k], resp_rdata[k]);
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b1; req_write[k] = 1'b1;
      req_addr[k] = '0; req_wdata[k] = '1; resp_ready[k] = 1'b1;
      clear_model(k);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; req_valid[k] = 1'b0; resp_ready[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0 || resp_rdata[k] !== '0 || resp_error[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst=%0d got r=%b v=%b e=%b d=%h want r=1 v=0 e=0 d=0",
                 k, req_ready[k], resp_valid[k], resp_error[k], resp_rdata[k]);
      end
    end
    txn(0, 1'b0, 64'h0, 64'h0, 0);
  endtask

  task automatic test_store_load;
    txn(0, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 0);
    txn(0, 1'b0, 64'h10, 64'h0, 0);
  endtask

  task automatic test_errors;
    txn(0, 1'b1, 64'h13, 64'h1111_2222_3333_4444, 0);
    txn(0, 1'b0, 64'h800, 64'h0, 0);
    txn(0, 1'b1, 64'h8000_0000_0000_0010, 64'h5555_6666_7777_8888, 0);
    txn(0, 1'b0, 64'h7F8, 64'h0, 0);
    txn(0, 1'b0, 64'h10, 64'h0, 0);
  endtask

  task automatic test_backpressure;
    txn(0, 1'b0, 64'h10, 64'h0, 5);
    txn(0, 1'b0, 64'h0, 64'h0, 0);
    txn(0, 1'b0, 64'h18, 64'h0, 0);
  endtask

  task automatic test_reset_in_wait;
    logic seen;
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0] = 64'h20; req_wdata[0] = 64'h1234;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    clear_model(0);
    seen = 1'b0;
    repeat (5) begin
      if (resp_valid[0] !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_noresp got resp_valid seen=%b want=0", seen);
    end
    txn(0, 1'b0, 64'h20, 64'h0, 0);
    txn(0, 1'b0, 64'h10, 64'h0, 0);
  endtask

  task automatic test_latency0;
    txn(1, 1'b0, 64'h0, 64'h0, 0);
    txn(1, 1'b1, 64'h40, 64'hA5A5_0000_FFFF_1234, 0);
    for (int i = 0; i < 6; i++)
      txn(1, 1'($urandom), W'($urandom_range(6, 10)) << 3, {$urandom, $urandom}, 0);
    txn(1, 1'b0, 64'h40, 64'h0, 2);
  endtask

  task automatic test_random;
    logic [W-1:0] addr;
    int k;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0, 1: addr = W'($urandom_range(0, 15)) << 3;
        2:    addr = W'($urandom_range(0, 255)) << 3;
        3:    addr = (W'($urandom_range(0, 255)) << 3) | W'($urandom_range(1, 7));
        default: addr = (W'($urandom_range(256, 4000)) << 3) | ({W'($urandom), 32'h0} & 64'h8000_0001_0000_0000);
      endcase
      txn(k, 1'($urandom), addr, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; resp_ready[k] = 1'b0;
    end
    test_reset;
    test_store_load;
    test_errors;
    test_backpressure;
    test_reset_in_wait;
    test_latency0;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
